ikascc_mapper_multi: RTL and testbench

//  Clocked, multi-mode MegaROM bank mapper; successor to the async Konami-SCC mapper. Samples MSX slot strobes in
//  the i_EMUCLK domain and commits bank writes on a synchronised /WR rising edge. Supports Konami-SCC, Konami,

---
 rtl/ikascc_pkg.sv | 44 ++++
 rtl/ikascc_sync_edge.sv | 31 +++
 rtl/ikascc_mapper_multi.sv | 156 +++++++++++++++
 tb/tb_ikascc_mapper_multi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ikascc_pkg.sv
// rtl/ikascc_pkg.sv - shared mode type, window constants and bank defaults for the MegaROM mapper
package ikascc_pkg;

   typedef enum logic [1:0] {
      MODE_KSCC  = 2'd0,
      MODE_KON   = 2'd1,
      MODE_ASC8  = 2'd2,
      MODE_ASC16 = 2'd3
   } mode_t;

   // SCC register window: A15..A11 = 10011 (0x9800) while bank2 selects page 0x3F
   localparam logic [4:0] SCC_WIN_ABHI = 5'b10011;
   localparam logic [7:0] SCC_WIN_BANK = 8'h3F;

   // Konami-SCC bank select windows (5000/7000/9000/B000)
   localparam logic [4:0] KSCC_WIN_B0 = 5'b01010;
   localparam logic [4:0] KSCC_WIN_B1 = 5'b01110;
   localparam logic [4:0] KSCC_WIN_B2 = 5'b10010;
   localparam logic [4:0] KSCC_WIN_B3 = 5'b10110;

   // Konami (no SCC) decodes only A15..A13; bank0 is fixed
   localparam logic [2:0] KON_WIN_B1 = 3'b011;
   localparam logic [2:0] KON_WIN_B2 = 3'b100;
   localparam logic [2:0] KON_WIN_B3 = 3'b101;

   // ASCII8 bank select windows (6000/6800/7000/7800)
   localparam logic [4:0] ASC8_WIN_B0 = 5'b01100;
   localparam logic [4:0] ASC8_WIN_B1 = 5'b01101;
   localparam logic [4:0] ASC8_WIN_B2 = 5'b01110;
   localparam logic [4:0] ASC8_WIN_B3 = 5'b01111;

   // ASCII16 writes a 16K bank as a pair of 8K banks
   localparam logic [4:0] ASC16_WIN_LO = 5'b01100;
   localparam logic [4:0] ASC16_WIN_HI = 5'b01110;

   // Bank value loaded at reset and on every mode change
   function automatic logic [7:0] bank_default(input logic [1:0] idx, input mode_t mode);
      if (mode == MODE_KON && idx == 2'd0) begin
         return 8'h00;
      end
      return {6'b000000, idx};
   endfunction

endpackage

// File: rtl/ikascc_sync_edge.sv
// rtl/ikascc_sync_edge.sv - multi-stage synchroniser for an idle-high strobe with rising-edge detect
module ikascc_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic level_d,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   // Shift the async strobe through the chain; idle-high so everything resets to 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         last_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign level   = sync_q[STAGES-1];
   assign level_d = last_q;
   assign rise    = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/ikascc_mapper_multi.sv
// rtl/ikascc_mapper_multi.sv - clocked multi-mode MegaROM bank mapper (Konami-SCC/Konami/ASCII8/ASCII16)
module ikascc_mapper_multi
   import ikascc_pkg::*;
#(
   parameter int BANK_W      = 6,
   parameter int SYNC_STAGES = 2,
   parameter int MODE_RST    = 0
) (
   input  logic              i_EMUCLK,
   input  logic              i_RST,
   input  logic              i_CS_n,
   input  logic              i_WR_n,
   input  logic              i_RD_n,
   input  logic [4:0]        i_ABHI,
   input  logic [7:0]        i_DB,
   input  logic [1:0]        i_MODE,
   output logic              o_ROMCS_n,
   output logic [BANK_W-1:0] o_ROMADDR,
   output logic              o_SCCREG_EN,
   output logic              o_BANKWR
);

   localparam mode_t RST_MODE = mode_t'(2'(MODE_RST));

   logic              wr_lvl, wr_rise, sync_wr_prev_unused;
   logic              cs_lvl, cs_prev, sync_cs_rise_unused;

   mode_t             mode_q;
   logic [BANK_W-1:0] bank_q   [4];
   logic [BANK_W-1:0] def_val  [4];
   logic [BANK_W-1:0] wr_val   [4];
   logic [3:0]        wr_en;
   logic [4:0]        cap_addr;
   logic [7:0]        cap_data;
   logic              bankwr_q;
   logic              commit;
   logic              mode_chg;
   logic [1:0]        page;
   logic              unused_cap;

   ikascc_sync_edge #(.STAGES(SYNC_STAGES)) u_wr_sync (
      .clk     (i_EMUCLK),
      .rst     (i_RST),
      .d       (i_WR_n),
      .level   (wr_lvl),
      .level_d (sync_wr_prev_unused),
      .rise    (wr_rise)
   );

   ikascc_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk     (i_EMUCLK),
      .rst     (i_RST),
      .d       (i_CS_n),
      .level   (cs_lvl),
      .level_d (cs_prev),
      .rise    (sync_cs_rise_unused)
   );

   // A write commits on the synchronised /WR rising edge if /CS was low on the sample before it;
   // a mode change is only taken while the slot is deselected and always beats a coincident commit
   assign commit   = wr_rise & ~cs_prev;
   assign mode_chg = cs_lvl & (i_MODE != mode_q);

   // Per-mode write decode of the captured address/data into bank enables and values
   always_comb begin
      wr_en = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         wr_val[i]  = cap_data[BANK_W-1:0];
         def_val[i] = BANK_W'(bank_default(2'(i), mode_t'(i_MODE)));
      end
      case (mode_q)
         MODE_KSCC: begin
            case (cap_addr)
               KSCC_WIN_B0: wr_en[0] = 1'b1;
               KSCC_WIN_B1: wr_en[1] = 1'b1;
               KSCC_WIN_B2: wr_en[2] = 1'b1;
               KSCC_WIN_B3: wr_en[3] = 1'b1;
               default: ;
            endcase
         end
         MODE_KON: begin
            case (cap_addr[4:2])
               KON_WIN_B1: wr_en[1] = 1'b1;
               KON_WIN_B2: wr_en[2] = 1'b1;
               KON_WIN_B3: wr_en[3] = 1'b1;
               default: ;
            endcase
         end
         MODE_ASC8: begin
            case (cap_addr)
               ASC8_WIN_B0: wr_en[0] = 1'b1;
               ASC8_WIN_B1: wr_en[1] = 1'b1;
               ASC8_WIN_B2: wr_en[2] = 1'b1;
               ASC8_WIN_B3: wr_en[3] = 1'b1;
               default: ;
            endcase
         end
         MODE_ASC16: begin
            wr_val[0] = {cap_data[BANK_W-2:0], 1'b0};
            wr_val[1] = {cap_data[BANK_W-2:0], 1'b1};
            wr_val[2] = {cap_data[BANK_W-2:0], 1'b0};
            wr_val[3] = {cap_data[BANK_W-2:0], 1'b1};
            if (cap_addr == ASC16_WIN_LO) begin
               wr_en[1:0] = 2'b11;
            end else if (cap_addr == ASC16_WIN_HI) begin
               wr_en[3:2] = 2'b11;
            end
         end
         default: ;
      endcase
   end

   // Bus capture, mode register, bank file and the commit pulse
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         mode_q   <= RST_MODE;
         bankwr_q <= 1'b0;
         cap_addr <= '0;
         cap_data <= '0;
         for (int i = 0; i < 4; i++) begin
            bank_q[i] <= BANK_W'(bank_default(2'(i), RST_MODE));
         end
      end else begin
         bankwr_q <= 1'b0;
         if (!wr_lvl) begin
            cap_addr <= i_ABHI;
            cap_data <= i_DB;
         end
         if (mode_chg) begin
            mode_q <= mode_t'(i_MODE);
            for (int i = 0; i < 4; i++) begin
               bank_q[i] <= def_val[i];
            end
         end else if (commit && (wr_en != 4'b0000)) begin
            for (int i = 0; i < 4; i++) begin
               if (wr_en[i]) begin
                  bank_q[i] <= wr_val[i];
               end
            end
            bankwr_q <= 1'b1;
         end
      end
   end

   // Read side is purely combinational: the page comes straight off the address bus
   assign page        = {~i_ABHI[3], i_ABHI[2]};
   assign o_ROMADDR   = bank_q[page];
   assign o_ROMCS_n   = i_CS_n | i_RD_n;
   assign o_SCCREG_EN = (mode_q == MODE_KSCC) && (8'(bank_q[2]) == SCC_WIN_BANK) &&
                        (i_ABHI == SCC_WIN_ABHI);
   assign o_BANKWR    = bankwr_q;

   // High data bits are captured but not stored when BANK_W < 8
   assign unused_cap = ^cap_data;

endmodule

// File: tb/tb_ikascc_mapper_multi.sv
// tb/tb_ikascc_mapper_multi.sv - directed scoreboard bench for ikascc_mapper_multi
`timescale 1ns/1ps
module tb_ikascc_mapper_multi;

   localparam int BANK_W      = 6;
   localparam int SYNC_STAGES = 2;

   logic              clk   = 1'b0;
   logic              rst   = 1'b1;
   logic              cs_n  = 1'b1;
   logic              wr_n  = 1'b1;
   logic              rd_n  = 1'b1;
   logic [4:0]        abhi  = 5'b0;
   logic [7:0]        db    = 8'h00;
   logic [1:0]        mode  = 2'd0;
   logic              romcs_n;
   logic [BANK_W-1:0] romaddr;
   logic              sccreg_en;
   logic              bankwr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pulse_q[$];

   ikascc_mapper_multi #(
      .BANK_W      (BANK_W),
      .SYNC_STAGES (SYNC_STAGES),
      .MODE_RST    (0)
   ) dut (
      .i_EMUCLK    (clk),
      .i_RST       (rst),
      .i_CS_n      (cs_n),
      .i_WR_n      (wr_n),
      .i_RD_n      (rd_n),
      .i_ABHI      (abhi),
      .i_DB        (db),
      .i_MODE      (mode),
      .o_ROMCS_n   (romcs_n),
      .o_ROMADDR   (romaddr),
      .o_SCCREG_EN (sccreg_en),
      .o_BANKWR    (bankwr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every o_BANKWR pulse must match the oldest expected commit cycle
   always @(posedge clk) begin
      #1;
      if (bankwr === 1'b1) begin
         checks++;
         assert (pulse_q.size() != 0 && pulse_q[0] == cyc) else begin
            errors++;
            $error("FAIL bankwr_pulse: observed pulse at cycle %0d, expected cycle %0d",
                   cyc, (pulse_q.size() != 0) ? pulse_q[0] : -1);
         end
         if (pulse_q.size() != 0) void'(pulse_q.pop_front());
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input int exp_bank, input int exp_scc);
      abhi = a;
      #1;
      check({tag, "_addr"}, 32'(romaddr), exp_bank);
      check({tag, "_scc"}, 32'(sccreg_en), exp_scc);
   endtask

   task automatic bus_begin(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      abhi = addr[15:11];
      db   = data;
      cs_n = 1'b0;
      wr_n = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic bus_raise(input bit expect_commit, input bit cs_too);
      wr_n = 1'b1;
      if (cs_too) cs_n = 1'b1;
      if (expect_commit) pulse_q.push_back(cyc + SYNC_STAGES + 1);
   endtask

   task automatic bus_end(input string tag);
      repeat (3) @(negedge clk);
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      check({tag, "_pending"}, 32'(pulse_q.size()), 0);
   endtask

   task automatic wr(input string tag, input logic [15:0] addr, input logic [7:0] data,
                     input bit expect_commit);
      bus_begin(addr, data);
      bus_raise(expect_commit, 1'b0);
      bus_end(tag);
   endtask

   task automatic set_mode(input logic [1:0] m);
      @(negedge clk);
      mode = m;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_bankwr", 32'(bankwr), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_bankwr", 32'(bankwr), 0);
      rd("rst_p0", 5'b01000, 0, 0);
      rd("rst_p1", 5'b01100, 1, 0);
      rd("rst_p2", 5'b10000, 2, 0);
      rd("rst_p3", 5'b10100, 3, 0);
      rd("rst_sccwin", 5'b10011, 2, 0);
      cs_n = 1'b0;
      rd_n = 1'b0;
      #1 check("romcs_active", 32'(romcs_n), 0);
      cs_n = 1'b1;
      #1 check("romcs_idle", 32'(romcs_n), 1);
      rd_n = 1'b1;

      // Konami-SCC: commit latency and SCC window
      bus_begin(16'h9000, 8'h3F);
      bus_raise(1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 check("kscc_lat_before", 32'(romaddr), 2);
      @(posedge clk);
      #1 check("kscc_lat_after", 32'(romaddr), 8'h3F);
      bus_end("kscc_b2_3f");
      rd("kscc_scc_on", 5'b10011, 8'h3F, 1);
      wr("kscc_b2_05", 16'h9000, 8'h05, 1'b1);
      rd("kscc_scc_off", 5'b10011, 8'h05, 0);
      wr("kscc_b0", 16'h5000, 8'h2A, 1'b1);
      rd("kscc_b0_rd", 5'b01000, 8'h2A, 0);
      wr("kscc_b1", 16'h7000, 8'h17, 1'b1);
      rd("kscc_b1_rd", 5'b01100, 8'h17, 0);
      wr("kscc_b3", 16'hB000, 8'hFC, 1'b1);
      rd("kscc_b3_rd", 5'b10100, 8'h3C, 0);
      wr("kscc_miss", 16'h6000, 8'h11, 1'b0);
      rd("kscc_miss_rd", 5'b01100, 8'h17, 0);

      // ASCII8
      set_mode(2'd2);
      rd("a8_def0", 5'b01000, 0, 0);
      rd("a8_def1", 5'b01100, 1, 0);
      rd("a8_def3", 5'b10100, 3, 0);
      wr("a8_b1", 16'h6800, 8'h12, 1'b1);
      rd("a8_b1_rd", 5'b01100, 8'h12, 0);
      wr("a8_b3", 16'h7800, 8'h34, 1'b1);
      rd("a8_b3_rd", 5'b10100, 8'h34, 0);
      wr("a8_b0_trunc", 16'h6000, 8'h52, 1'b1);
      rd("a8_b0_rd", 5'b01000, 8'h12, 0);
      wr("a8_b2_trunc", 16'h7000, 8'hC7, 1'b1);
      rd("a8_b2_rd", 5'b10000, 8'h07, 0);

      // ASCII16
      set_mode(2'd3);
      rd("a16_def2", 5'b10000, 2, 0);
      wr("a16_hi", 16'h7000, 8'h07, 1'b1);
      rd("a16_b2_rd", 5'b10000, 8'h0E, 0);
      rd("a16_b3_rd", 5'b10100, 8'h0F, 0);
      wr("a16_miss", 16'h6800, 8'h05, 1'b0);
      rd("a16_miss_b0", 5'b01000, 0, 0);
      rd("a16_miss_b1", 5'b01100, 1, 0);
      wr("a16_lo", 16'h6000, 8'h03, 1'b1);
      rd("a16_b0_rd", 5'b01000, 8'h06, 0);
      rd("a16_b1_rd", 5'b01100, 8'h07, 0);

      // Konami
      set_mode(2'd1);
      rd("kon_def0", 5'b01000, 0, 0);
      rd("kon_def3", 5'b10100, 3, 0);
      wr("kon_4000_miss", 16'h4000, 8'h11, 1'b0);
      rd("kon_b0_rd", 5'b01000, 0, 0);
      wr("kon_b3", 16'hA000, 8'h09, 1'b1);
      rd("kon_b3_rd", 5'b10100, 8'h09, 0);
      wr("kon_b1", 16'h6000, 8'h0B, 1'b1);
      rd("kon_b1_rd", 5'b01100, 8'h0B, 0);
      wr("kon_5000_miss", 16'h5000, 8'h22, 1'b0);
      rd("kon_b0_rd2", 5'b01000, 0, 0);

      // Mode change deferred while selected, then wins over a coincident commit
      set_mode(2'd0);
      wr("sim_setup", 16'h9000, 8'h3F, 1'b1);
      rd("sim_setup_scc", 5'b10011, 8'h3F, 1);
      bus_begin(16'h5000, 8'h21);
      mode = 2'd2;
      repeat (2) @(negedge clk);
      rd("defer_scc", 5'b10011, 8'h3F, 1);
      abhi = 5'b01010;
      @(negedge clk);
      bus_raise(1'b0, 1'b1);
      bus_end("sim");
      rd("sim_b0", 5'b01000, 0, 0);
      rd("sim_b1", 5'b01100, 1, 0);
      rd("sim_b3", 5'b10100, 3, 0);
      rd("sim_sccwin", 5'b10011, 2, 0);
      wr("sim_mode2", 16'h6800, 8'h15, 1'b1);
      rd("sim_mode2_rd", 5'b01100, 8'h15, 0);

      // Reset in the middle of a write: nothing commits after release
      set_mode(2'd0);
      bus_begin(16'h5000, 8'h2B);
      @(negedge clk);
      rst  = 1'b1;
      wr_n = 1'b1;
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("rstmid_bankwr", 32'(bankwr), 0);
      check("rstmid_pending", 32'(pulse_q.size()), 0);
      rd("rstmid_b0", 5'b01000, 0, 0);
      rd("rstmid_b2", 5'b10000, 2, 0);

      check("final_pending", 32'(pulse_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
